audio_pingpong_ctrl: RTL
========================

# audio_pingpong_ctrl

Controller that owns a single-port sample RAM on the audio side of the DSP path: it writes stereo samples from the I2S receiver into a ping-pong (double-banked) frame buffer, announces each completed frame to the processing engine, and arbitrates the one RAM port between the non-stallable audio writer and the DSP reader. It sits between `i2s_rx` (after the samples are synchronized into `clk`) and the DSP block.

## Interface
- `WORD_SIZE`, 32: sample word width.
- `FRAME_LEN`, 64: samples per channel per frame; power of 2, ≥ 2.
- `IDX_W`, $clog2(FRAME_LEN): index width. RAM address width is IDX_W+2, laid out as {bank, chan, idx} with chan 0 = L, 1 = R.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: one-cycle pulse; `in_l` and `in_r` are valid.
- `in_l`, `in_r` in WORD_SIZE: stereo sample pair.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out IDX_W+2: RAM address.
- `ram_din` out WORD_SIZE: RAM write data.
- `ram_dout` in WORD_SIZE: RAM read data, valid 1 cycle after its address is presented.
- `rd_req` in 1: DSP read request, held until granted.
- `rd_chan` in 1 and `rd_idx` in IDX_W: read location within the ready bank.
- `rd_gnt` out 1: the read address is on the RAM port this cycle.
- `rd_valid` out 1 and `rd_data` out WORD_SIZE: read data return.
- `frame_ready` out 1: a complete frame is available.
- `frame_bank` out 1: bank that holds the ready frame.
- `frame_done` in 1: pulse; DSP has finished the current frame.
- `ovr_clr` in 1: clears both overrun flags.
- `sample_ovr` out 1 and `frame_ovr` out 1: sticky overrun flags.

## Operation
- Writer FSM states:
  - IDLE: `in_valid` latches `in_l`/`in_r` into hold registers and moves to WR_L.
  - WR_L: writes L to {wr_bank, 0, wr_idx}, then moves to WR_R.
  - WR_R: writes R to {wr_bank, 1, wr_idx}, then moves to IDLE and advances wr_idx.
- Writer owns the port in WR_L and WR_R, and always wins over the reader.
- Frame completion: when WR_R writes at wr_idx = FRAME_LEN-1:
  - wr_idx wraps to 0 and wr_bank toggles.
  - In the next cycle, `frame_ready` = 1 and `frame_bank` = the bank just filled.
- Frame overrun: completion while `frame_ready` is already 1 and `frame_done` is 0 sets `frame_ovr`. `frame_ready` stays 1 and `frame_bank` updates to the newest bank, because audio is never stalled.
- `frame_done` while `frame_ready` = 1 clears `frame_ready`. When `frame_ready` = 0, `frame_done` is ignored.
- `frame_done` and completion in the same cycle: `frame_ready` stays 1, `frame_bank` updates to the new bank, and no overrun is flagged.
- Sample overrun: `in_valid` while the FSM is in WR_L or WR_R sets `sample_ovr` and drops the new pair. The in-flight pair completes unchanged.
- Reader port:
  - A read is issued for a cycle only when the writer will not use the port in that cycle, `rd_req` = 1 and `frame_ready` = 1. Reads are never issued while `frame_ready` = 0.
  - Read address is {frame_bank, rd_chan, rd_idx}.
  - If `rd_req` stays high after `rd_gnt`, back-to-back reads issue at 1 per cycle; the DSP updates `rd_chan`/`rd_idx` in the cycle after `rd_gnt`.
- `ovr_clr` clears both flags. If a set event occurs in the same cycle, set wins.
- Reset values: `ram_we` 0, `ram_addr` 0, `ram_din` 0, `rd_gnt` 0, `rd_valid` 0, `rd_data` 0, `frame_ready` 0, `frame_bank` 0, `sample_ovr` 0, `frame_ovr` 0. Internally: FSM IDLE, wr_bank 0, wr_idx 0.
- Reset mid-frame discards the partial frame and any ready frame.

## Timing
- All outputs are registered.
- Write path: `in_valid` at cycle T (FSM IDLE).
  - T+1: `ram_we` = 1 with the L address and data.
  - T+2: `ram_we` = 1 with the R address and data.
  - T+3: FSM IDLE. `frame_ready` rises here if T+2 wrote the last index.
  - A new `in_valid` is accepted from T+3 onward; `in_valid` at T+1 or T+2 is an overrun.
- Arbitration is decided at cycle T for the port use at T+1.
  - Writer claims T+1 if `in_valid` (FSM IDLE) at T, or FSM = WR_L at T.
  - Otherwise a qualifying `rd_req` at T claims T+1: `rd_gnt` = 1 with `ram_we` = 0 and the read address at T+1, then `rd_valid` = 1 with `rd_data` = `ram_dout` at T+2.
- `rd_valid` is a 1-cycle pulse per grant.
- Worst-case read stall: 2 cycles per sample pair.

## Test plan
- Fill frame: 64 pairs (L = i, R = 0x100+i), one every 8 cycles → 128 writes; R of pair i goes to addr 64+i; `frame_ready` = 1 and `frame_bank` = 0 three cycles after the last `in_valid`. Read back all 128 words via `rd_req` and check each `rd_data`.
- Contention: `rd_req` held continuously while pairs arrive → writes never delayed; `rd_gnt` is absent in the write cycles; every `rd_valid` arrives 1 cycle after its `rd_gnt` with the correct data.
- Ping-pong: `frame_done` after frame 0 is read, then fill frame 1 → `frame_bank` = 1, writes land in addr 128-255, `frame_ovr` stays 0.
- Frame overrun: fill two frames without `frame_done` → `frame_ovr` = 1 and `frame_bank` = 1. `ovr_clr` → 0. `frame_done` coincident with completion → no flag.
- Sample overrun: `in_valid` at T and T+1 → `sample_ovr` = 1; only the T pair is written; wr_idx advances by 1.
- Reset after 30 pairs → all outputs at reset values. A subsequent fill of 64 pairs starts at addr 0 and completes with `frame_bank` = 0.

Source files
------------

// File: rtl/audio_pingpong_ctrl.sv
// Ping-pong frame buffer controller: writes stereo I2S pairs into a double-banked
// single-port RAM, announces finished frames and lets the DSP read in idle slots.
module audio_pingpong_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_l,
  input  logic [WORD_SIZE-1:0] in_r,

  output logic                 ram_we,
  output logic [IDX_W+1:0]     ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout,

  input  logic                 rd_req,
  input  logic                 rd_chan,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,

  output logic                 frame_ready,
  output logic                 frame_bank,
  input  logic                 frame_done,

  input  logic                 ovr_clr,
  output logic                 sample_ovr,
  output logic                 frame_ovr
);

  localparam int AW = IDX_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR_L = 2'd1;
  localparam logic [1:0] S_WR_R = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]           state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [WORD_SIZE-1:0] hold_r_q;

  logic                 ram_we_q, ram_we_d;
  logic [AW-1:0]        ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0] ram_din_q, ram_din_d;
  logic                 rd_gnt_q, rd_gnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 frame_bank_q, frame_bank_d;
  logic                 sample_ovr_q, sample_ovr_d;
  logic                 frame_ovr_q, frame_ovr_d;

  logic                 accept;
  logic                 wr_claim;
  logic                 rd_issue;
  logic                 frame_cmpl;

  // The writer owns the next cycle's port slot when a pair is accepted now or
  // when the L write is on the port now (R follows immediately).
  assign accept     = (state_q == S_IDLE) && in_valid;
  assign wr_claim   = accept || (state_q == S_WR_L);
  assign rd_issue   = !wr_claim && rd_req && frame_ready_q;
  assign frame_cmpl = (state_q == S_WR_R) && (wr_idx_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    rd_gnt_d      = 1'b0;
    rd_valid_d    = rd_gnt_q;
    frame_ready_d = frame_ready_q;
    frame_bank_d  = frame_bank_q;
    sample_ovr_d  = sample_ovr_q;
    frame_ovr_d   = frame_ovr_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_WR_L;
          ram_we_d   = 1'b1;
          ram_addr_d = {wr_bank_q, 1'b0, wr_idx_q};
          ram_din_d  = in_l;
        end
      end
      S_WR_L: begin
        state_d    = S_WR_R;
        ram_we_d   = 1'b1;
        ram_addr_d = {wr_bank_q, 1'b1, wr_idx_q};
        ram_din_d  = hold_r_q;
      end
      S_WR_R: begin
        state_d  = S_IDLE;
        // FRAME_LEN is a power of two, so the index wraps to 0 on its own.
        wr_idx_d = wr_idx_q + 1'b1;
        if (frame_cmpl) begin
          wr_bank_d = ~wr_bank_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rd_issue) begin
      rd_gnt_d   = 1'b1;
      ram_addr_d = {frame_bank_q, rd_chan, rd_idx};
    end

    // Audio never stalls: a new frame always becomes the ready one.
    if (frame_cmpl) begin
      frame_ready_d = 1'b1;
      frame_bank_d  = wr_bank_q;
    end else if (frame_done && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end

    if (ovr_clr) begin
      sample_ovr_d = 1'b0;
      frame_ovr_d  = 1'b0;
    end
    if (in_valid && (state_q != S_IDLE)) begin
      sample_ovr_d = 1'b1;
    end
    if (frame_cmpl && frame_ready_q && !frame_done) begin
      frame_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      rd_gnt_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      sample_ovr_q  <= 1'b0;
      frame_ovr_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      rd_gnt_q      <= rd_gnt_d;
      rd_valid_q    <= rd_valid_d;
      frame_ready_q <= frame_ready_d;
      frame_bank_q  <= frame_bank_d;
      sample_ovr_q  <= sample_ovr_d;
      frame_ovr_q   <= frame_ovr_d;
    end
  end

  // R sample waits here while L occupies the port.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_r_q <= in_r;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign rd_gnt      = rd_gnt_q;
  assign rd_valid    = rd_valid_q;
  // RAM output register is the final flop on the read path; gate keeps rd_data 0 between returns.
  assign rd_data     = rd_valid_q ? ram_dout : '0;
  assign frame_ready = frame_ready_q;
  assign frame_bank  = frame_bank_q;
  assign sample_ovr  = sample_ovr_q;
  assign frame_ovr   = frame_ovr_q;

endmodule
